puf_response_gen: RTL and testbench
===================================

# puf_response_gen

Sequencer that sits upstream and downstream of a pair of RO_withCounter instances (RO A, RO B). For each response bit it:
- applies a 6-bit challenge slice to both rings;
- resets their counters;
- runs them for a fixed window, then stops them and lets them quiesce;
- compares the frozen counts and shifts one bit into the response register.

The result is an N_BITS PUF response with a valid strobe, for the UART/SSEG readout logic.

## Interface
Parameters:
- N_BITS, 16, response bits per challenge
- SETTLE, 4, cycles ro_reset is held per bit
- WINDOW, 150000, cycles ro_enable is high per bit
- QUIET, 8, cycles after ro_enable falls before counts are sampled

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- challenge  in  6*N_BITS  bit i uses challenge[6i+5:6i] = {sel[2:0], bx[2:0]}
- count_a  in  16  secCounter count from RO A
- count_b  in  16  secCounter count from RO B
- ro_enable  out  1  enable to both ROs
- ro_reset  out  1  reset to both RO counter chains
- ro_sel  out  3  sel to both ROs
- ro_bx  out  3  bx to both ROs
- response  out  N_BITS  response, bit 0 = first measured
- valid  out  1  high while response holds a complete result
- busy  out  1  high in any state except IDLE
- tie_cnt  out  8  bits whose counts were equal in the last run (saturates at 255)
- sat_err  out  1  sticky: a count read 16'hFFFF in the last run

## Operation
- The challenge is latched into an internal register on an accepted start; later changes to the input are ignored until the next start.
- States: IDLE, RST, RUN, STOP, CMP, DONE.
- IDLE:
  - ro_enable=0, ro_reset=0.
  - start -> RST, with bit index=0, response cleared, valid=0, tie_cnt=0, sat_err=0.
- RST:
  - ro_reset=1, ro_enable=0, ro_sel/ro_bx = slice[idx].
  - After SETTLE cycles -> RUN.
- RUN:
  - ro_reset=0, ro_enable=1, config held.
  - After WINDOW cycles -> STOP.
- STOP:
  - ro_enable=0, config held.
  - After QUIET cycles -> CMP. Counts are static from here, because the oscillators are stopped. No synchroniser is needed beyond the QUIET settling.
- CMP (1 cycle):
  - response[idx] = (count_a > count_b).
  - Tie: bit = 0, tie_cnt += 1 (saturating).
  - Either count == 16'hFFFF: sat_err = 1.
  - idx == N_BITS-1 -> DONE, else idx+1 -> RST.
- DONE:
  - valid=1, one cycle -> IDLE.
  - valid stays high in IDLE until the next accepted start.
- ro_sel/ro_bx outside RST..CMP: 0.
- start while busy: ignored.
- reset in any state: takes effect at the next edge, returning to IDLE with all outputs at reset values. The RO counters are not reset by this block in that case; the next run's RST phase clears them.

## Timing
- Reset values:
  - state=IDLE;
  - response=0, valid=0, busy=0, tie_cnt=0, sat_err=0;
  - ro_enable=0, ro_reset=0, ro_sel=0, ro_bx=0.
- All outputs are registered.
- start sampled at edge k -> busy=1 and ro_reset=1 from edge k+1.
- Per bit: SETTLE + WINDOW + QUIET + 1 cycles.
- Total from start edge to valid rising: N_BITS*(SETTLE+WINDOW+QUIET+1)+1 cycles.
- ro_enable and ro_reset are never both high.
- Config changes only on entry to RST, never while ro_enable=1.
- Comparison is unsigned 16-bit.

## Structure
- Package puf_pkg holds:
  - state enum puf_state_t;
  - CFG_W=6, COUNT_W=16;
  - a function slice_cfg(challenge, idx) returning {sel, bx}.
- Sub-module phase_timer: loadable down-counter.
  - Ports: clk, reset, load, load_val, expired.
  - Width is $clog2 of max(SETTLE, WINDOW, QUIET)+1.
  - Shared by all three timed states.

## Test plan
Benches use N_BITS=4, SETTLE=2, WINDOW=8, QUIET=3. Behavioural RO model: count rises by 1 per clk while enabled; RO B runs at 1/2 rate when bx[0]=1.
- Challenge all zero, both models at equal rate -> response=4'b0000, tie_cnt=4, sat_err=0, valid high at cycle 4*14+1=57 after start.
- Slices with bx[0]=1 for bits 0 and 2 -> response=4'b0101, tie_cnt=2.
- Force count_a=16'hFFFF during bit 1 -> sat_err=1 after CMP of bit 1, response[1]=1.
- start pulsed again mid-RUN -> ignored; completion time and response unchanged.
- reset asserted during STOP of bit 2 -> next edge: IDLE, busy=0, valid=0, all RO outputs 0. A new start runs a full 57-cycle sequence.
- Assertions throughout:
  - never ro_enable&&ro_reset;
  - ro_sel/ro_bx stable while ro_enable=1;
  - ro_reset is high for exactly SETTLE cycles per bit.

Source files
------------

// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, widths and challenge slicing for the PUF response sequencer.
package puf_pkg;
    localparam int CFG_W = 6;
    localparam int COUNT_W = 16;
    localparam int MAX_BITS = 256;
    typedef enum logic [2:0] {IDLE, RST, RUN, STOP, CMP, DONE} puf_state_t;
    typedef logic [CFG_W*MAX_BITS-1:0] chal_t;
    function automatic logic [CFG_W-1:0] slice_cfg(input chal_t challenge, input int unsigned idx);
        return challenge[CFG_W*idx +: CFG_W];
    endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter, expired while the count sits at zero.
module phase_timer #(
    parameter int W = 8
) (
    input logic clk,
    input logic reset,
    input logic load,
    input logic [W-1:0] load_val,
    output logic expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/puf_response_gen.sv
// puf_response_gen: sequences two ring oscillators per challenge slice and builds the PUF response.
module puf_response_gen
    import puf_pkg::*;
#(
    parameter int N_BITS = 16,
    parameter int SETTLE = 4,
    parameter int WINDOW = 150000,
    parameter int QUIET = 8
) (
    input logic clk,
    input logic reset,
    input logic start,
    input logic [CFG_W*N_BITS-1:0] challenge,
    input logic [COUNT_W-1:0] count_a,
    input logic [COUNT_W-1:0] count_b,
    output logic ro_enable,
    output logic ro_reset,
    output logic [2:0] ro_sel,
    output logic [2:0] ro_bx,
    output logic [N_BITS-1:0] response,
    output logic valid,
    output logic busy,
    output logic [7:0] tie_cnt,
    output logic sat_err
);
    localparam int MAX_T = SETTLE > WINDOW ? (SETTLE > QUIET ? SETTLE : QUIET) : (WINDOW > QUIET ? WINDOW : QUIET);
    localparam int TW = $clog2(MAX_T + 1);
    localparam int IW = N_BITS > 1 ? $clog2(N_BITS) : 1;

    puf_state_t state, state_n;
    logic [IW-1:0] idx;
    logic [CFG_W*N_BITS-1:0] chal;
    logic [CFG_W-1:0] cfg;
    logic [TW-1:0] load_val;
    logic load, expired, accept;

    // busy lags the state by one cycle, so gating on it keeps start ignored until busy has dropped
    assign accept = state == IDLE && start && !busy;
    assign cfg = slice_cfg(chal_t'(chal), 32'(idx));

    phase_timer #(.W(TW)) timer (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .expired(expired)
    );

    always_comb begin
        state_n = state;
        load = 1'b0;
        load_val = '0;
        case (state)
            IDLE: if (accept) begin
                state_n = RST;
                load = 1'b1;
                load_val = TW'(SETTLE - 1);
            end
            RST: if (expired) begin
                state_n = RUN;
                load = 1'b1;
                load_val = TW'(WINDOW - 1);
            end
            RUN: if (expired) begin
                state_n = STOP;
                load = 1'b1;
                load_val = TW'(QUIET - 1);
            end
            STOP: if (expired) state_n = CMP;
            CMP: begin
                state_n = idx == IW'(N_BITS - 1) ? DONE : RST;
                load = state_n == RST;
                load_val = TW'(SETTLE - 1);
            end
            default: state_n = IDLE;
        endcase
    end

    // RO controls are registered decodes of the current state, so they trail it by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            chal <= '0;
            response <= '0;
            valid <= 1'b0;
            busy <= 1'b0;
            tie_cnt <= '0;
            sat_err <= 1'b0;
            ro_enable <= 1'b0;
            ro_reset <= 1'b0;
            ro_sel <= '0;
            ro_bx <= '0;
        end else begin
            state <= state_n;
            busy <= state != IDLE;
            ro_reset <= state == RST;
            ro_enable <= state == RUN;
            {ro_sel, ro_bx} <= state inside {RST, RUN, STOP, CMP} ? cfg : '0;
            if (accept) begin
                chal <= challenge;
                idx <= '0;
                response <= '0;
                valid <= 1'b0;
                tie_cnt <= '0;
                sat_err <= 1'b0;
            end
            if (state == DONE) valid <= 1'b1;
            if (state == CMP) begin
                response[idx] <= count_a > count_b;
                if (count_a == count_b && tie_cnt != 8'hFF) tie_cnt <= tie_cnt + 8'd1;
                if (count_a == 16'hFFFF || count_b == 16'hFFFF) sat_err <= 1'b1;
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_puf_response_gen.sv
// tb_puf_response_gen: random and directed runs against a rate-based ring oscillator model.
module tb_puf_response_gen;
    localparam int N_BITS = 4;
    localparam int SETTLE = 2;
    localparam int WINDOW = 8;
    localparam int QUIET = 3;
    localparam int PER_BIT = SETTLE + WINDOW + QUIET + 1;
    localparam int LATENCY = N_BITS * PER_BIT + 1;

    logic clk, reset, start;
    logic [23:0] challenge;
    logic [15:0] count_a, count_b;
    logic ro_enable, ro_reset, valid, busy, sat_err;
    logic [2:0] ro_sel, ro_bx;
    logic [3:0] response;
    logic [7:0] tie_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int mon_viol = 0;
    logic [23:0] cur_chal;
    logic [3:0] force_mask;
    int bit_no = -1;
    logic [15:0] a_cnt, b_cnt;
    logic ph, prev_rst, prev_en;
    logic [5:0] prev_cfg;
    int rst_len = 0;
    int en_len = 0;

    puf_response_gen #(.N_BITS(N_BITS), .SETTLE(SETTLE), .WINDOW(WINDOW), .QUIET(QUIET)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .challenge(challenge),
        .count_a(count_a),
        .count_b(count_b),
        .ro_enable(ro_enable),
        .ro_reset(ro_reset),
        .ro_sel(ro_sel),
        .ro_bx(ro_bx),
        .response(response),
        .valid(valid),
        .busy(busy),
        .tie_cnt(tie_cnt),
        .sat_err(sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring oscillator pair plus protocol monitors: A counts every enabled cycle, B every other one when bx[0]=1
    always @(negedge clk) begin
        if (!busy) bit_no = -1;
        else if (ro_reset && !prev_rst) bit_no++;
        if (reset || ro_reset) begin
            a_cnt = '0;
            b_cnt = '0;
            ph = 1'b0;
        end else if (ro_enable) begin
            a_cnt++;
            if (!ro_bx[0] || ph) b_cnt++;
            ph = !ph;
        end
        count_a = (bit_no >= 0 && force_mask[bit_no]) ? 16'hFFFF : a_cnt;
        count_b = b_cnt;
        assert (!(ro_enable && ro_reset)) else begin
            mon_viol++;
            $error("FAIL en_rst_overlap: observed enable=%0b reset=%0b expected not both", ro_enable, ro_reset);
        end
        if (ro_enable && prev_en) assert ({ro_sel, ro_bx} === prev_cfg) else begin
            mon_viol++;
            $error("FAIL cfg_stable: observed %0h expected %0h", {ro_sel, ro_bx}, prev_cfg);
        end
        if (ro_reset && bit_no >= 0) assert ({ro_sel, ro_bx} === cur_chal[6*bit_no +: 6]) else begin
            mon_viol++;
            $error("FAIL cfg_slice%0d: observed %0h expected %0h", bit_no, {ro_sel, ro_bx}, cur_chal[6*bit_no +: 6]);
        end
        if (!busy) assert (!ro_enable && !ro_reset && {ro_sel, ro_bx} == 6'd0) else begin
            mon_viol++;
            $error("FAIL idle_ro: observed en=%0b rst=%0b cfg=%0h expected all 0", ro_enable, ro_reset, {ro_sel, ro_bx});
        end
        if (ro_reset) rst_len++;
        else begin
            if (rst_len != 0) assert (rst_len == SETTLE) else begin
                mon_viol++;
                $error("FAIL rst_len: observed %0d expected %0d", rst_len, SETTLE);
            end
            rst_len = 0;
        end
        if (ro_enable) en_len++;
        else begin
            if (en_len != 0) assert (en_len == WINDOW) else begin
                mon_viol++;
                $error("FAIL en_len: observed %0d expected %0d", en_len, WINDOW);
            end
            en_len = 0;
        end
        prev_rst = ro_reset;
        prev_en = ro_enable;
        prev_cfg = {ro_sel, ro_bx};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_resp"}, 32'(response), 0);
        chk({tag, "_tie"}, 32'(tie_cnt), 0);
        chk({tag, "_sat"}, 32'(sat_err), 0);
        chk({tag, "_ro"}, 32'({ro_enable, ro_reset, ro_sel, ro_bx}), 0);
    endtask

    // One challenge run; poke_at pulses start mid-run, abort_at applies reset at that cycle (0 = unused)
    task automatic do_run(input logic [23:0] ch, input logic [3:0] fm, input int poke_at, input int abort_at);
        logic [3:0] er;
        int et, cyc, b;
        logic es;
        logic [15:0] ma, mb;
        er = '0;
        et = 0;
        es = 1'b0;
        @(negedge clk);
        challenge = ch;
        cur_chal = ch;
        force_mask = fm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        chk("valid_clr", 32'(valid), 0);
        chk("busy_lag", 32'(busy), 0);
        while (!valid && cyc < 2 * LATENCY) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("busy_up", 32'(busy), 1);
                chk("rst_up", 32'(ro_reset), 1);
            end
            if (cyc == 2) challenge = 24'($urandom);
            if (cyc == poke_at) begin
                start = 1'b1;
                challenge = 24'($urandom);
            end else start = 1'b0;
            if (cyc == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_idle_outputs("abort");
                return;
            end
            if (cyc % PER_BIT == 0 && cyc <= N_BITS * PER_BIT) begin
                b = cyc / PER_BIT - 1;
                ma = fm[b] ? 16'hFFFF : 16'(WINDOW);
                mb = ch[6*b] ? 16'(WINDOW / 2) : 16'(WINDOW);
                er[b] = ma > mb;
                et += int'(ma == mb);
                es |= ma == 16'hFFFF || mb == 16'hFFFF;
                chk($sformatf("resp_bit%0d", b), 32'(response), 32'(er));
                chk($sformatf("tie_bit%0d", b), 32'(tie_cnt), 32'(et));
                chk($sformatf("sat_bit%0d", b), 32'(sat_err), 32'(es));
            end
        end
        chk("latency", 32'(cyc), LATENCY);
        chk("final_resp", 32'(response), 32'(er));
        chk("final_tie", 32'(tie_cnt), 32'(et));
        chk("final_sat", 32'(sat_err), 32'(es));
        repeat (3) @(negedge clk);
        chk("hold_valid", 32'(valid), 1);
        chk("hold_busy", 32'(busy), 0);
        chk("hold_resp", 32'(response), 32'(er));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        challenge = '0;
        cur_chal = '0;
        force_mask = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        do_run(24'h000000, 4'b0000, 0, 0);
        do_run(24'h001001, 4'b0000, 0, 0);
        do_run(24'h000000, 4'b0010, 0, 0);
        do_run(24'($urandom), 4'b0000, 20, 0);
        do_run(24'($urandom), 4'b0000, 0, 2 * PER_BIT + SETTLE + WINDOW + 1);
        do_run(24'($urandom), 4'b0000, 0, 0);
        for (int i = 0; i < 4; i++) do_run(24'($urandom), 4'($urandom), 0, 0);
        chk("monitor", 32'(mon_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
